// File: rtl/countdown_mmss.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_mmss
//  Purpose  : Minutes:seconds countdown timer. Loaded with a clamped MM:SS
//             preset, it decrements once per tick while running. It pulses
//             bo when the seconds field wraps 00->59 and flags done at 00:00.
//  Ports    : clk            - system clock, rising-edge active
//             clr            - asynchronous active-low reset
//             load           - load min_in/sec_in (clamped to 59) as preset
//             min_in, sec_in - preset minutes / seconds (6 bits each)
//             start          - begin or resume counting
//             pause          - freeze counting
//             tick           - one-cycle count enable
//             min, sec       - current count (0-59 per field)
//             bo             - one-cycle borrow pulse on seconds wrap
//             busy           - high while counting (RUN)
//             done           - high from 00:00 until next load or reset
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_mmss (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       bo,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] c_FIELD_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic [5:0] w_min_nxt;
  logic [5:0] w_sec_nxt;
  logic       r_bo;
  logic       w_bo_nxt;

  // State and count registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_min   <= 6'd0;
      r_sec   <= 6'd0;
      r_bo    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
      r_bo    <= w_bo_nxt;
    end
  end

  // Next-state / next-count logic. The if-else chain encodes the input
  // priority load > start > pause > tick; an input that is not acted on
  // simply falls through to the next one, so nothing is queued.
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_bo_nxt    = 1'b0;

    if (load) begin
      w_min_nxt   = (min_in > c_FIELD_MAX) ? c_FIELD_MAX : min_in;
      w_sec_nxt   = (sec_in > c_FIELD_MAX) ? c_FIELD_MAX : sec_in;
      w_state_nxt = IDLE;
    end else if (start && (r_state == IDLE || r_state == PAUSE)) begin
      // Starting from 00:00 expires immediately without ever running
      if (r_min == 6'd0 && r_sec == 6'd0) begin
        w_state_nxt = DONE;
      end else begin
        w_state_nxt = RUN;
      end
    end else if (pause && r_state == RUN) begin
      w_state_nxt = PAUSE;
    end else if (tick && r_state == RUN) begin
      if (r_sec != 6'd0) begin
        w_sec_nxt = r_sec - 6'd1;
        if (r_min == 6'd0 && r_sec == 6'd1) begin
          w_state_nxt = DONE;
        end
      end else if (r_min != 6'd0) begin
        w_sec_nxt = c_FIELD_MAX;
        w_min_nxt = r_min - 6'd1;
        w_bo_nxt  = 1'b1;
      end else begin
        // RUN is never entered at 00:00; recover to DONE should it happen
        w_state_nxt = DONE;
      end
    end
  end

  assign min  = r_min;
  assign sec  = r_sec;
  assign bo   = r_bo;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown_mmss.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_mmss
//  Purpose  : Directed self-checking bench for countdown_mmss.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_mmss;

  logic       clk;
  logic       clr;
  logic       load;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic       start;
  logic       pause;
  logic       tick;
  logic [5:0] min;
  logic [5:0] sec;
  logic       bo;
  logic       busy;
  logic       done;

  int vec_cnt;
  int err_cnt;

  countdown_mmss dut (
    .clk    (clk),
    .clr    (clr),
    .load   (load),
    .min_in (min_in),
    .sec_in (sec_in),
    .start  (start),
    .pause  (pause),
    .tick   (tick),
    .min    (min),
    .sec    (sec),
    .bo     (bo),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Check the whole observable state in one go
  task automatic chk_all(input string tag, input int e_min, input int e_sec,
                         input int e_bo, input int e_busy, input int e_done);
    chk({tag, "_min"},  int'(min),  e_min);
    chk({tag, "_sec"},  int'(sec),  e_sec);
    chk({tag, "_bo"},   int'(bo),   e_bo);
    chk({tag, "_busy"}, int'(busy), e_busy);
    chk({tag, "_done"}, int'(done), e_done);
  endtask

  // Apply one cycle of controls, sample 1 time unit after the edge
  task automatic cyc(input logic l, input logic s, input logic p, input logic t);
    load  = l;
    start = s;
    pause = p;
    tick  = t;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    min_in = m;
    sec_in = s;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Watchdog: stimulus is bounded, but never allow a hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bo_cnt;
    int bo_prev;
    vec_cnt = 0;
    err_cnt = 0;
    clr    = 1'b0;
    load   = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    tick   = 1'b0;
    min_in = 6'd0;
    sec_in = 6'd0;

    // Reset state
    #3;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("idle_tick", 0, 0, 0, 0, 0);

    // Reset mid-count: 10:30, 5 ticks -> 10:25, then async clear
    do_load(6'd10, 6'd30);
    chk_all("load_1030", 10, 30, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("start_1030", 10, 30, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("run_1025", 10, 25, 0, 1, 0);
    #2;
    clr = 1'b0;
    #1;
    chk_all("async_clr", 0, 0, 0, 0, 0);
    @(negedge clk);
    clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("post_clr", 0, 0, 0, 0, 0);

    // Minute borrow
    do_load(6'd1, 6'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("borrow", 0, 59, 1, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("borrow_gap", 0, 59, 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("borrow_next", 0, 58, 0, 1, 0);

    // Expiry
    do_load(6'd0, 6'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("exp_0001", 0, 1, 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("exp_0000", 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("exp_tick", 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk_all("exp_start", 0, 0, 0, 0, 1);
    do_load(6'd0, 6'd3);
    chk_all("exp_reload", 0, 3, 0, 0, 0);

    // Clamp and full run with tick held high
    do_load(6'd63, 6'd60);
    chk_all("clamp", 59, 59, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    bo_cnt  = 0;
    bo_prev = 0;
    tick = 1'b1;
    for (int i = 1; i <= 3599; i++) begin
      @(posedge clk);
      #1;
      if (bo) bo_cnt++;
      if (bo && bo_prev != 0) chk("bo_double", 1, 0);
      bo_prev = int'(bo);
      if (i == 60) chk_all("clamp_t60", 58, 59, 1, 1, 0);
    end
    tick = 1'b0;
    chk_all("clamp_end", 0, 0, 0, 0, 1);
    chk("clamp_bo_cnt", bo_cnt, 59);

    // Zero start
    do_load(6'd0, 6'd0);
    chk_all("zero_load", 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("zero_start", 0, 0, 0, 0, 1);

    // Collisions from RUN at 00:10
    do_load(6'd0, 6'd10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("col_run", 0, 10, 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("col_pause_tick", 0, 10, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("col_paused_tick", 0, 10, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("col_resume", 0, 10, 0, 1, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk_all("col_run_start_tick", 0, 9, 0, 1, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("col_run_start_pause", 0, 9, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("col_restart", 0, 9, 0, 1, 0);
    min_in = 6'd0;
    sec_in = 6'd5;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("col_load_tick", 0, 5, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("col_idle_tick", 0, 5, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_mmss.md
# countdown_mmss

Minutes:seconds countdown timer, the down-counting counterpart to the team's modulo-60 up-counter. It is loaded with a preset MM:SS (each field 0–59) and decrements once per `tick` enable. Each time the seconds field wraps 00→59 it emits a one-cycle borrow pulse `bo`, the mirror of the up-counter's carry `co`. It asserts `done` on reaching 00:00. It sits between the second-tick prescaler and the display/alarm logic of the timer datapath.

## Interface
- No parameters; field modulus fixed at 60, widths fixed at 6 bits.
- `clk`  in  1  system clock, all state updates on rising edge.
- `clr`  in  1  asynchronous active-low reset.
- `load`  in  1  load `min_in`/`sec_in` as new preset.
- `min_in`  in  6  preset minutes.
- `sec_in`  in  6  preset seconds.
- `start`  in  1  begin or resume counting.
- `pause`  in  1  freeze counting.
- `tick`  in  1  one-cycle count enable, nominally 1 Hz.
- `min`  out  6  current minutes, 0–59.
- `sec`  out  6  current seconds, 0–59.
- `bo`  out  1  borrow pulse, high one cycle when `sec` wraps 0→59.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  high from reaching 00:00 until next load or reset.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- Input priority per cycle: `load` > `start` > `pause` > `tick`. Lower-priority inputs that are not acted on in a cycle are dropped, not queued.
- `load` (any state):
  - Sets `min` to min(`min_in`, 59) and `sec` to min(`sec_in`, 59).
  - Next state IDLE; `done`=0, `bo`=0.
- `start`:
  - In IDLE or PAUSE: if count is 00:00, go to DONE with `done`=1; otherwise go to RUN.
  - In RUN or DONE: ignored. A DONE timer requires `load` before it can restart.
- `pause`: in RUN, go to PAUSE and hold the count. In every other state it is ignored.
- `start` and `pause` in the same cycle:
  - In RUN, `start` is ignored, so `pause` takes effect.
  - In PAUSE, `start` takes effect and the timer resumes.
- `tick` is acted on only in RUN, and only when none of `load`/`start`/`pause` was acted on that cycle:
  - `sec`>0: `sec` decrements by 1, `bo`=0.
  - `sec`=0, `min`>0: `sec`=59, `min` decrements by 1, `bo`=1.
  - If the new value is 00:00, next state is DONE and `done`=1 on the same edge.
- `bo` is 0 in every cycle not covered above; it is never high for more than one consecutive cycle.
- All arithmetic is unsigned 6-bit. Out-of-range presets are clamped at load, so the count is always within 0–59 per field.
- Reset mid-operation: asynchronous `clr`=0 immediately forces state IDLE, `min`=0, `sec`=0, `bo`=0, `busy`=0, `done`=0. Counting resumes only after `clr` deasserts, followed by `load` and `start`.

## Timing
- All outputs are registered. Every response appears after the rising edge that samples the stimulus, i.e. 1-cycle latency.
- `busy` is decoded from the registered state: it rises the edge after `start` and falls the edge after `pause`, `load`, or the final tick.
- `bo` coincides with the edge on which `sec` becomes 59.
- `done` coincides with the edge on which the count becomes 00:00.
- `tick` may be held high continuously; the timer then decrements once per clock while in RUN.
- Reset assertion is asynchronous. Reset release must meet recovery/removal timing against `clk`.

## Test plan
- Reset mid-count: load 10:30, start, 5 ticks, assert `clr`=0 between edges -> outputs go to 00:00 with `busy`=`bo`=`done`=0 immediately, before the next edge.
- Minute borrow: load 01:00, start, 1 tick -> 00:59 with `bo`=1 for exactly one cycle; the next tick -> 00:58 with `bo`=0.
- Expiry: load 00:02, start, 2 ticks -> 00:01, then 00:00 with `done`=1 and `busy`=0. Further ticks and `start` leave 00:00/`done`=1 unchanged.
- Clamp: load `min_in`=63, `sec_in`=60 -> 59:59. Run 3599 ticks -> 00:00/`done`=1 with exactly 59 `bo` pulses.
- Zero start: load 00:00, start -> next cycle state DONE with `done`=1 and `busy` never high.
- Collisions, starting from RUN at 00:10:
  - `pause`+`tick` together -> count holds at 00:10, state PAUSE.
  - Then `start`+`pause` together -> resumes RUN.
  - Then `load`(00:05)+`tick` together -> 00:05, state IDLE.
